// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
package adder_pkg;

  // Operation select carried with every operand beat.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Number of pipeline stages: one CHUNK-bit slice per stage.
  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the ripple-through-pipeline adder.
//   a_s, b_s : operand slices (b_s already inverted for subtract)
//   c_in     : carry from the previous slice
//   s        : slice sum
//   c_out    : carry into the next slice
module adder_stage #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out
);

  assign {c_out, s} = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, c_in};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit, one CHUNK-bit slice per stage,
// valid/ready on both sides with full backpressure.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational)
//   a, b, cin, mode     : operands, carry/borrow-in, op (adder_pkg::op_e)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry-out (SUB: 1 = no borrow), signed overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);
  localparam int unsigned LAST   = STAGES - 1;

  // Per-stage registers: a/b_eff travel whole (upper slices act as skew,
  // lower slices of s act as alignment of already-finished results).
  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
  logic                         ovf_q, ovf_d;

  // Combinational inputs seen by each stage this cycle.
  logic [STAGES-1:0]            st_v;
  logic [STAGES-1:0]            st_c;
  logic [STAGES-1:0][WIDTH-1:0] st_a;
  logic [STAGES-1:0][WIDTH-1:0] st_b;
  logic [STAGES-1:0][WIDTH-1:0] st_s;
  logic [STAGES-1:0][CHUNK-1:0] slice_s;
  logic [STAGES-1:0]            slice_c;

  logic advance;
  logic is_sub;

  // Whole pipe moves together whenever the output slot is free or drained.
  assign advance  = !v_q[LAST] || out_ready;
  assign in_ready = advance;
  assign is_sub   = (op_e'(mode) == OP_SUB);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] s_new;

    if (k == 0) begin : g_first
      // Subtract folds into add: a + ~b + !borrow_in.
      assign st_v[k] = in_valid;
      assign st_a[k] = a;
      assign st_b[k] = is_sub ? ~b : b;
      assign st_c[k] = is_sub ? ~cin : cin;
      assign st_s[k] = '0;
    end else begin : g_rest
      assign st_v[k] = v_q[k-1];
      assign st_a[k] = a_q[k-1];
      assign st_b[k] = b_q[k-1];
      assign st_c[k] = c_q[k-1];
      assign st_s[k] = s_q[k-1];
    end

    adder_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .a_s   (st_a[k][k*CHUNK +: CHUNK]),
      .b_s   (st_b[k][k*CHUNK +: CHUNK]),
      .c_in  (st_c[k]),
      .s     (slice_s[k]),
      .c_out (slice_c[k])
    );

    // Insert this stage's slice into the partially finished result.
    always_comb begin
      s_new = st_s[k];
      s_new[k*CHUNK +: CHUNK] = slice_s[k];
    end

    // Next state: load on advance, otherwise hold (valid bits included).
    assign v_d[k] = advance ? st_v[k]    : v_q[k];
    assign a_d[k] = advance ? st_a[k]    : a_q[k];
    assign b_d[k] = advance ? st_b[k]    : b_q[k];
    assign c_d[k] = advance ? slice_c[k] : c_q[k];
    assign s_d[k] = advance ? s_new      : s_q[k];
  end

  // Overflow: operands agree in sign but result sign differs.
  assign ovf_d = advance
               ? ((st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                  (slice_s[LAST][CHUNK-1] != st_a[LAST][WIDTH-1]))
               : ovf_q;

  // Pipeline state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  // Consumed slices of the operand skew registers are intentionally dead.
  logic unused_skew_bits;
  assign unused_skew_bits = ^{a_q, b_q};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4).
module tb_pipelined_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  pipelined_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic mv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    mode     = mv;
  endtask

  // Single beat: accept, confirm nothing after 3 cycles, result on the 4th.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic mv, input logic [15:0] es,
                        input logic ec, input logic eo);
    @(negedge clk);
    drive(av, bv, cv, mv);
    out_ready = 1'b1;
    #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, " early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
  endtask

  logic [15:0] mix_s [3];
  logic        mix_c [3];
  logic        mix_o [3];
  logic [15:0] held;
  logic        held_ok;
  int          sent;
  int          rcvd;
  int          stall_seen;
  int          idx;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Arithmetic vectors
    run_op("add small",   16'h000F, 16'h000C, 1'b1, 1'b0, 16'h001C, 1'b0, 1'b0);
    run_op("add ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub neg",     16'h0003, 16'h0009, 1'b0, 1'b1, 16'hFFFA, 1'b0, 1'b0);
    run_op("sub ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add carry",   16'hF300, 16'h4900, 1'b0, 1'b0, 16'h3C00, 1'b1, 1'b0);
    run_op("sub borrowin",16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Back-to-back beats with mixed modes
    mix_s[0] = 16'h2345; mix_c[0] = 1'b0; mix_o[0] = 1'b0;
    mix_s[1] = 16'h0FFF; mix_c[1] = 1'b1; mix_o[1] = 1'b0;
    mix_s[2] = 16'h0000; mix_c[2] = 1'b1; mix_o[2] = 1'b1;
    @(negedge clk); drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk); drive(16'h1234, 16'h0234, 1'b1, 1'b1);
    @(negedge clk); drive(16'h8000, 16'h8000, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 12 && idx < 3; c++) begin
      #1;
      if (out_valid) begin
        check("mix sum", 32'(sum), 32'(mix_s[idx]));
        check("mix cout", 32'(cout), 32'(mix_c[idx]));
        check("mix ovf", 32'(ovf), 32'(mix_o[idx]));
        idx++;
      end
      @(negedge clk);
    end
    check("mix count", 32'(idx), 32'd3);

    // Backpressure: 8 beats a=b=i, consumer stalls in cycles 3..8
    sent       = 0;
    rcvd       = 0;
    stall_seen = 0;
    held       = '0;
    held_ok    = 1'b0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 8);
      if (sent < 8) drive(16'(sent), 16'(sent), 1'b0, 1'b0);
      else in_valid = 1'b0;
      #1;
      if (!in_ready) begin
        stall_seen++;
        check("bp in flight at stall", 32'(sent - rcvd), 32'd4);
      end
      if (out_valid && !out_ready) begin
        if (held_ok) check("bp stable sum", 32'(sum), 32'(held));
        held    = sum;
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("bp order", 32'(sum), 32'(2 * rcvd));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp received", 32'(rcvd), 32'd8);
    check("bp stall cycles", 32'(stall_seen), 32'd5);

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(16'h0100, 16'h0200, 1'b0, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    check("pre-rst sum", 32'(sum), 32'h0300);
    rst = 1'b1;
    #1;
    check("rst async out_valid", 32'(out_valid), 32'd0);
    check("rst async sum", 32'(sum), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 check("post-rst no stale", 32'(out_valid), 32'd0);
    end
    run_op("post-rst add", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
